// File: rtl/keypad_conditioner.sv
// Keypad front end: per-key two-flop synchroniser and debouncer, plus a press arbiter
// that emits one pulse per accepted press and flags simultaneous presses.
module keypad_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic btnA,
    input  logic btnB,
    input  logic btnC,
    input  logic btnD,
    output logic outA,
    output logic outB,
    output logic outC,
    output logic outD,
    output logic conflict,
    output logic key_down
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [3:0]       btn_s;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       stable_q;
    logic [3:0]       stable_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    state_t           state_q;
    logic [3:0]       key_q;
    logic             conflict_q;
    logic             key_down_q;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    assign btn_s = {btnD, btnC, btnB, btnA};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= btn_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: a level change is accepted only after N consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = CNT_ZERO;
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = CNT_ZERO;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = CNT_ZERO;
            end else begin
                cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            stable_q <= stable_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Press arbiter: one pulse per press, then wait for every key to be released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= 4'b0000;
            conflict_q <= 1'b0;
            key_down_q <= 1'b0;
        end else begin
            key_down_q <= |stable_q;
            key_q      <= 4'b0000;
            conflict_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_one_hot(stable_q)) begin
                        key_q   <= stable_q;
                        state_q <= HELD;
                    end else if (stable_q != 4'b0000) begin
                        conflict_q <= 1'b1;
                        state_q    <= HELD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HELD: begin
                    if (stable_q == 4'b0000) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= HELD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign outA     = key_q[0];
    assign outB     = key_q[1];
    assign outC     = key_q[2];
    assign outD     = key_q[3];
    assign conflict = conflict_q;
    assign key_down = key_down_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Scoreboard bench for keypad_conditioner: a window-based reference model predicts
// pulses and key_down; a negedge monitor compares what the DUT presents.
module tb_keypad_conditioner;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btnA = 1'b0, btnB = 1'b0, btnC = 1'b0, btnD = 1'b0;
    logic outA, outB, outC, outD, conflict, key_down;

    keypad_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .btnA(btnA), .btnB(btnB), .btnC(btnC), .btnD(btnD),
        .outA(outA), .outB(outB), .outC(outC), .outD(outD),
        .conflict(conflict), .key_down(key_down)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  code;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    exp_t        q[$];
    bit [3:0]    hist[$];
    bit [3:0]    m_stable;
    bit          m_held;
    bit          m_kd;
    int          obs_cnt[5];
    int unsigned last_cyc[5];
    int          base[5];

    task automatic model_reset();
        hist.delete();
        for (int j = 0; j < N + 2; j++) hist.push_back(4'b0000);
        m_stable = 4'b0000;
        m_held   = 1'b0;
        m_kd     = 1'b0;
        q.delete();
    endtask

    always @(posedge rst) model_reset();

    // Reference model: a key's level flips once the last N synchronised samples
    // (raw samples delayed by two edges) all disagree with the accepted level.
    always @(posedge clk) begin
        bit [3:0] s;
        bit [3:0] nxt;
        bit       flip;
        exp_t     e;
        cyc++;
        if (rst) begin
            model_reset();
        end else begin
            s = {btnD, btnC, btnB, btnA};
            hist.push_back(s);
            void'(hist.pop_front());
            nxt = m_stable;
            for (int i = 0; i < 4; i++) begin
                flip = 1'b1;
                for (int j = 0; j < N; j++) if (hist[j][i] == m_stable[i]) flip = 1'b0;
                if (flip) nxt[i] = ~m_stable[i];
            end
            if (!m_held) begin
                if ($countones(m_stable) == 1) begin
                    e.cyc = cyc; e.code = {1'b0, m_stable}; q.push_back(e); m_held = 1'b1;
                end else if ($countones(m_stable) >= 2) begin
                    e.cyc = cyc; e.code = 5'b10000; q.push_back(e); m_held = 1'b1;
                end
            end else if (m_stable == 4'b0000) begin
                m_held = 1'b0;
            end
            m_kd     = |m_stable;
            m_stable = nxt;
        end
    end

    // Monitor: compare presented pulses against the scoreboard queue.
    always @(negedge clk) begin
        logic [4:0] code;
        exp_t       e;
        if (!rst) begin
            code = {conflict, outD, outC, outB, outA};
            checks++;
            if (key_down !== m_kd) begin
                failures++;
                $display("FAIL key_down cyc=%0d actual=%b expected=%b", cyc, key_down, m_kd);
            end
            for (int k = 0; k < 5; k++) if (code[k] === 1'b1) begin
                obs_cnt[k]++;
                last_cyc[k] = cyc;
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checks++;
                if (code !== e.code) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d actual=%b expected=%b", cyc, code, e.code);
                end
            end else if (code != 5'b00000) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d actual=%b expected=00000", cyc, code);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic snap();
        for (int k = 0; k < 5; k++) base[k] = obs_cnt[k];
    endtask

    function automatic int delta(input int k);
        return obs_cnt[k] - base[k];
    endfunction

    initial begin
        int unsigned k0;
        int r, dur;
        logic [3:0] m;
        for (int k = 0; k < 5; k++) begin obs_cnt[k] = 0; last_cyc[k] = 0; end

        tick(3); #1;
        check("reset_outs", {conflict, outD, outC, outB, outA}, 0);
        check("reset_key_down", key_down, 0);
        rst = 1'b0;
        tick(5);

        // 1: clean press of B
        snap();
        btnB = 1'b1; k0 = cyc + 1;
        tick(25); #1;
        check("s1_key_down", key_down, 1);
        tick(15);
        btnB = 1'b0;
        tick(N + 10); #1;
        check("s1_outB_count", delta(1), 1);
        check("s1_other_count", delta(0) + delta(2) + delta(3) + delta(4), 0);
        check("s1_latency", last_cyc[1], k0 + 18);

        // 2: bouncing C then held
        snap();
        btnC = 1'b1; tick(3); btnC = 1'b0; tick(3);
        btnC = 1'b1; tick(3); btnC = 1'b0; tick(3);
        btnC = 1'b1; k0 = cyc + 1;
        tick(30);
        btnC = 1'b0;
        tick(N + 10); #1;
        check("s2_outC_count", delta(2), 1);
        check("s2_latency", last_cyc[2], k0 + 18);

        // 3: simultaneous A+D, then A alone
        snap();
        btnA = 1'b1; btnD = 1'b1;
        tick(30);
        btnA = 1'b0; btnD = 1'b0;
        tick(N + 10); #1;
        check("s3_conflict_count", delta(4), 1);
        check("s3_outAD_count", delta(0) + delta(3), 0);
        snap();
        btnA = 1'b1; k0 = cyc + 1;
        tick(30);
        btnA = 1'b0;
        tick(N + 10); #1;
        check("s3_outA_count", delta(0), 1);
        check("s3_outA_latency", last_cyc[0], k0 + 18);

        // 4: B pressed while A held is ignored
        btnA = 1'b1; tick(25);
        snap();
        btnB = 1'b1; tick(25);
        btnA = 1'b0; tick(30); #1;
        check("s4_ignored_B", delta(1), 0);
        btnB = 1'b0; tick(N + 5);
        snap();
        btnB = 1'b1; k0 = cyc + 1;
        tick(30);
        btnB = 1'b0;
        tick(N + 10); #1;
        check("s4_outB_count", delta(1), 1);
        check("s4_outB_latency", last_cyc[1], k0 + 18);

        // 5: reset mid-debounce of D
        btnA = 1'b1; tick(25); #1;
        check("s5_key_down_pre", key_down, 1);
        btnD = 1'b1; tick(10);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        check("s5_async_outs", {conflict, outD, outC, outB, outA}, 0);
        check("s5_async_key_down", key_down, 0);
        btnA = 1'b0;
        tick(3);
        snap();
        rst = 1'b0; k0 = cyc + 1;
        tick(30); #1;
        check("s5_outD_count", delta(3), 1);
        check("s5_outD_latency", last_cyc[3], k0 + 18);
        btnD = 1'b0;
        tick(N + 10);

        // 6: single-cycle glitch on A
        snap();
        btnA = 1'b1; tick(1); btnA = 1'b0;
        tick(N + 10); #1;
        check("s6_no_pulse", delta(0) + delta(1) + delta(2) + delta(3) + delta(4), 0);
        check("s6_key_down", key_down, 0);

        // Random segments: mostly single keys, some idle, some multi-key.
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      m = 4'b0001 << $urandom_range(0, 3);
            else if (r < 7) m = 4'b0000;
            else            m = 4'($urandom_range(0, 15));
            {btnD, btnC, btnB, btnA} = m;
            dur = $urandom_range(1, 40);
            tick(dur);
        end
        {btnD, btnC, btnB, btnA} = 4'b0000;
        tick(N + 10); #1;
        check("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
